seg_display_capture: RTL

//  Receive end of the multiplexed 7-segment bus (an/seg/dp, all active-low) driven by the display mux.

---
 rtl/seg_display_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg_display_capture.sv
// Capture side of a multiplexed active-low 7-segment bus: qualifies each digit dwell,
// inverse-decodes it and rebuilds four {dp_on,hex} codes. Optional SEG_CAPTURE_CHANGE_EN adds the changed pulse.
module seg_display_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    output logic [4:0] d0,
    output logic [4:0] d1,
    output logic [4:0] d2,
    output logic [4:0] d3,
    output logic [3:0] valid,
    output logic       frame_done,
    output logic       bad_pattern,
    output logic       changed
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    // sample layout {an[3:0], seg[6:0], dp}
    logic [11:0]          s_q, s_d, sp_q;
    logic [CW-1:0]        c_q, c_d;
    logic [3:0][4:0]      d_q, d_d;
    logic [3:0]           valid_q, valid_d;
    logic [3:0][TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]           mask_q, mask_d;
    logic                 frame_q, frame_d;
    logic                 bad_q, bad_d;
`ifdef SEG_CAPTURE_CHANGE_EN
    logic                 chg_q, chg_d;
`endif

    logic [3:0] an_low;
    logic       one_hot;
    logic [1:0] idx;
    logic       capture;
    logic [4:0] dec;
    logic [4:0] new_code;
    logic [3:0] mask_set;

    // returns {decodable, hex}
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h40: seg_decode = 5'h10;
            7'h79: seg_decode = 5'h11;
            7'h24: seg_decode = 5'h12;
            7'h30: seg_decode = 5'h13;
            7'h19: seg_decode = 5'h14;
            7'h12: seg_decode = 5'h15;
            7'h02: seg_decode = 5'h16;
            7'h78: seg_decode = 5'h17;
            7'h00: seg_decode = 5'h18;
            7'h10: seg_decode = 5'h19;
            7'h08: seg_decode = 5'h1A;
            7'h03: seg_decode = 5'h1B;
            7'h46: seg_decode = 5'h1C;
            7'h21: seg_decode = 5'h1D;
            7'h06: seg_decode = 5'h1E;
            7'h0E: seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        s_d      = {an, seg, dp};
        an_low   = ~s_q[11:8];
        one_hot  = (an_low != 4'b0) && ((an_low & (an_low - 4'b1)) == 4'b0);
        idx      = 2'd0;
        case (an_low)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase

        if (!one_hot)            c_d = '0;
        else if (s_q != sp_q)    c_d = CW'(1);
        else if (c_q != C_MAX)   c_d = c_q + CW'(1);
        else                     c_d = c_q;
        // fires only on the transition into saturation, so one capture per dwell
        capture  = (c_d == C_MAX) && (c_q != C_MAX);

        dec      = seg_decode(s_q[7:1]);
        new_code = {~s_q[0], dec[3:0]};
        mask_set = mask_q | (4'b1 << idx);

        d_d      = d_q;
        mask_d   = mask_q;
        frame_d  = 1'b0;
        bad_d    = 1'b0;
`ifdef SEG_CAPTURE_CHANGE_EN
        chg_d    = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            tcnt_d[i]  = (tcnt_q[i] == T_MAX) ? tcnt_q[i] : tcnt_q[i] + TW'(1);
            valid_d[i] = valid_q[i] && (tcnt_d[i] != T_MAX);
        end

        if (capture) begin
            if (dec[4]) begin
`ifdef SEG_CAPTURE_CHANGE_EN
                chg_d = !valid_q[idx] || (d_q[idx] != new_code);
`endif
                d_d[idx]     = new_code;
                valid_d[idx] = 1'b1;
                tcnt_d[idx]  = '0;
                if (mask_set == 4'b1111) begin
                    frame_d = 1'b1;
                    mask_d  = 4'b0;
                end else begin
                    mask_d  = mask_set;
                end
            end else begin
                bad_d        = 1'b1;
                valid_d[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q     <= '0;
            sp_q    <= '0;
            c_q     <= '0;
            d_q     <= '0;
            valid_q <= '0;
            tcnt_q  <= '0;
            mask_q  <= '0;
            frame_q <= 1'b0;
            bad_q   <= 1'b0;
`ifdef SEG_CAPTURE_CHANGE_EN
            chg_q   <= 1'b0;
`endif
        end else begin
            s_q     <= s_d;
            sp_q    <= s_q;
            c_q     <= c_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            tcnt_q  <= tcnt_d;
            mask_q  <= mask_d;
            frame_q <= frame_d;
            bad_q   <= bad_d;
`ifdef SEG_CAPTURE_CHANGE_EN
            chg_q   <= chg_d;
`endif
        end
    end

    assign d0          = d_q[0];
    assign d1          = d_q[1];
    assign d2          = d_q[2];
    assign d3          = d_q[3];
    assign valid       = valid_q;
    assign frame_done  = frame_q;
    assign bad_pattern = bad_q;
`ifdef SEG_CAPTURE_CHANGE_EN
    assign changed     = chg_q;
`else
    assign changed     = 1'b0;
`endif
endmodule
